mem_burst_master: RTL and testbench
===================================

# mem_burst_master

Initiator-side controller that drives the main memory port on behalf of a pipeline client such as instruction fetch or a cache line fill. It accepts one request at a time, which is either a single-word write or a 1/4/8/16-word burst read. It sequences the memory enable, address, access-size and write-enable signals, then returns read beats to the client with a beat index and a last flag.

## Interface
Parameters:
- ADDRESS_SIZE, 32: address width.
- DATA_SIZE, 32: word width.
- ACCESS_SIZE, 2: access-size code width.
- START_ADDRESS, 32'h80020000: base of the memory window (used only with MEM_ADDR_CHECK_EN).
- MEM_SIZE, 1048578: memory size in bytes (used only with MEM_ADDR_CHECK_EN).

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  1  client request present.
- req_ready  out  1  block can accept a request. Reset value 1.
- req_wr  in  1  1 = single-word write, 0 = burst read.
- req_addr  in  ADDRESS_SIZE  byte address of word 0.
- req_size  in  ACCESS_SIZE  burst code: 00=1, 01=4, 10=8, 11=16 words. Ignored (forced to 00) for writes.
- req_wdata  in  DATA_SIZE  write data.
- rsp_valid  out  1  rsp_data holds a read beat. Reset value 0.
- rsp_data  out  DATA_SIZE  read beat. Equals mem_d_out while rsp_valid=1.
- rsp_index  out  4  beat number, starting at 0. Reset value 0.
- rsp_last  out  1  final beat of the burst. Reset value 0.
- wr_done  out  1  one-cycle pulse when a write completes. Reset value 0.
- req_err  out  1  one-cycle pulse when a request is rejected. Reset value 0. Tied to 0 without the macro.
- mem_addr  out  ADDRESS_SIZE  memory address. Reset value 0.
- mem_acc_size  out  ACCESS_SIZE  memory access size. Reset value 00.
- mem_en  out  1  memory enable. Reset value 0.
- mem_wren  out  1  memory write enable. Reset value 0.
- mem_d_in  out  DATA_SIZE  write data to memory. Reset value 0.
- mem_d_out  in  DATA_SIZE  registered read data from memory.
- mem_busy  in  1  memory burst-in-progress. Monitored only; it never gates the state machine.

## Operation
- States: IDLE, ACCESS, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size, wr and wdata, and compute N = 1/4/8/16 (1 for writes).
  - Go to ACCESS.
- ACCESS:
  - mem_en=1 for exactly N consecutive cycles.
  - mem_addr, mem_acc_size, mem_wren and mem_d_in are held constant for all N cycles. The memory increments its internal offset itself.
  - A 5-bit issue counter counts 0..N-1.
  - After the last issue cycle, go to DRAIN.
- DRAIN:
  - One cycle for the final beat to return, then go to IDLE.
- Read capture:
  - A one-cycle-delayed copy of (mem_en & ~mem_wren) drives rsp_valid.
  - A 4-bit beat counter drives rsp_index.
  - rsp_last=1 when rsp_index == N-1.
- Write: wr_done pulses in the DRAIN cycle. rsp_valid stays 0.
- No response backpressure: the client must take each beat in the cycle rsp_valid=1.
- Requests presented while req_ready=0 are ignored and not queued.
- Reset in any state:
  - Next cycle the state is IDLE and all outputs take their reset values.
  - Outstanding beats are discarded. rsp_valid must not assert for them.

## Timing
- t0: req_valid & req_ready is sampled.
- t1..tN: mem_en=1.
- Read beat k is presented in cycle t(k+2), so rsp_valid is high over t2..t(N+1).
- Latency from acceptance to the first beat: 2 cycles. Beats are back-to-back.
- req_ready=0 over t1..t(N+1) and returns to 1 at t(N+2).
- Write:
  - mem_en=mem_wren=1 at t1.
  - wr_done at t2.
  - req_ready=1 at t3.
- Minimum request spacing: N+2 cycles.
- Beat counter widths: issue counter 5 bits, rsp_index 4 bits. Neither wraps within one burst.

## Configuration
- MEM_ADDR_CHECK_EN defined: at acceptance, the block rejects a request if any of the following hold:
  - req_addr[1:0] != 0.
  - req_addr < START_ADDRESS.
  - req_addr - START_ADDRESS + 4N > MEM_SIZE.

  A rejected request:
  - pulses req_err at t1;
  - never asserts mem_en;
  - returns req_ready=1 at t2.
- Not defined: no checks. req_err is constant 0, and every request is issued.

## Test plan
- Reset: assert rst for 2 cycles mid-idle -> all outputs at their reset values and req_ready=1.
- Single read at 0x80020000, size 00, memory preloaded with 0xDEADBEEF:
  - mem_en for 1 cycle;
  - rsp_valid at t2 with data 0xDEADBEEF, index 0, last=1;
  - req_ready=1 at t3.
- Burst of 16 at 0x80020040:
  - mem_en for 16 cycles with mem_addr held;
  - 16 consecutive beats with indices 0..15, last only on 15, data matching the preload;
  - req_ready=1 at t18.
- Write 0x12345678 to 0x80020010, then a size-00 read of the same address:
  - write: wr_done at t2, no rsp_valid;
  - read: returns 0x12345678.
- rst asserted at t4 of an 8-word burst -> mem_en=0 and rsp_valid=0 from t5 on. The next request completes normally.
- With MEM_ADDR_CHECK_EN, a read at 0x80020002 and a read at 0x8001FFFC -> req_err at t1 for each, mem_en never asserts, req_ready=1 at t2.

Source files
------------

// File: rtl/mem_burst_master.sv
// -----------------------------------------------------------------------------
// mem_burst_master
//
// Initiator-side controller for the main memory port. It accepts one client
// request at a time: a single-word write, or a 1/4/8/16-word burst read. For
// an accepted request it raises mem_en for N consecutive cycles while holding
// the address, access size, write enable and write data steady. The memory
// walks through the burst itself. Read beats come back one cycle behind each
// enabled cycle and are tagged with a beat index and a last flag.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid/req_ready                      request handshake
//   req_wr, req_addr, req_size, req_wdata    request fields (size code
//                                            00/01/10/11 = 1/4/8/16 words)
//   rsp_valid, rsp_data, rsp_index, rsp_last read beats (no backpressure)
//   wr_done        one-cycle pulse when a write completes
//   req_err        one-cycle pulse when a request is rejected
//   mem_addr, mem_acc_size, mem_en, mem_wren, mem_d_in    memory command
//   mem_d_out      registered read data from memory
//   mem_busy       memory burst-in-progress (monitored only)
//
// Build option
//   MEM_ADDR_CHECK_EN  when defined, rejects misaligned requests and requests
//                      that fall outside [START_ADDRESS, START_ADDRESS+MEM_SIZE).
//                      When undefined, req_err is constant 0.
// -----------------------------------------------------------------------------
module mem_burst_master #(
  parameter int unsigned              ADDRESS_SIZE  = 32,
  parameter int unsigned              DATA_SIZE     = 32,
  parameter int unsigned              ACCESS_SIZE   = 2,
  parameter logic [ADDRESS_SIZE-1:0]  START_ADDRESS = 32'h8002_0000,
  parameter int unsigned              MEM_SIZE      = 1048578
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [ACCESS_SIZE-1:0]  req_size,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_SIZE-1:0]    rsp_data,
  output logic [3:0]              rsp_index,
  output logic                    rsp_last,
  output logic                    wr_done,
  output logic                    req_err,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [4:0]              issue_cnt_q, issue_cnt_d;
  logic [3:0]              last_idx_q, last_idx_d;    // N-1 of the current request
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [ACCESS_SIZE-1:0]  mem_acc_size_q, mem_acc_size_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_wren_q, mem_wren_d;
  logic [DATA_SIZE-1:0]    mem_d_in_q, mem_d_in_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [3:0]              rsp_index_q, rsp_index_d;
  logic                    wr_done_q, wr_done_d;
  logic                    req_err_q, req_err_d;

  logic [3:0]              req_last_idx;
  logic                    reject;

  // Size code to last beat index: 00/01/10/11 -> 0/3/7/15.
  function automatic logic [3:0] last_idx_of(input logic [1:0] code);
    unique case (code)
      2'b00:   return 4'd0;
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  // Writes are always one word, whatever the client put on req_size.
  assign req_last_idx = req_wr ? 4'd0 : last_idx_of(req_size[1:0]);

`ifdef MEM_ADDR_CHECK_EN
  localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE+1)'(MEM_SIZE);

  logic [6:0]              req_bytes;
  logic [ADDRESS_SIZE:0]   req_span;
  logic                    unused_inputs;

  // One extra bit keeps offset + 4N from wrapping near the top of the map.
  assign req_bytes = {({1'b0, req_last_idx} + 5'd1), 2'b00};
  assign req_span  = {1'b0, req_addr - START_ADDRESS} + (ADDRESS_SIZE+1)'(req_bytes);
  assign reject    = (req_addr[1:0] != 2'b00) || (req_addr < START_ADDRESS) ||
                     (req_span > MEM_LIMIT);
  assign unused_inputs = mem_busy;
`else
  logic unused_cfg;

  assign reject     = 1'b0;
  assign unused_cfg = ^{mem_busy, START_ADDRESS, MEM_SIZE[0]};
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value before the case, so
    // no path through the logic leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    issue_cnt_d    = issue_cnt_q;
    last_idx_d     = last_idx_q;
    mem_addr_d     = mem_addr_q;
    mem_acc_size_d = mem_acc_size_q;
    mem_en_d       = mem_en_q;
    mem_wren_d     = mem_wren_q;
    mem_d_in_d     = mem_d_in_q;
    wr_done_d      = 1'b0;
    req_err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (reject) begin
            // Rejected requests never touch memory; DRAIN supplies the
            // one busy cycle before req_ready returns.
            req_err_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            mem_addr_d     = req_addr;
            mem_acc_size_d = req_wr ? '0 : req_size;
            mem_wren_d     = req_wr;
            mem_d_in_d     = req_wdata;
            last_idx_d     = req_last_idx;
            issue_cnt_d    = '0;
            mem_en_d       = 1'b1;
            state_d        = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (issue_cnt_q == {1'b0, last_idx_q}) begin
          mem_en_d  = 1'b0;
          wr_done_d = mem_wren_q;
          state_d   = ST_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;   // ST_DRAIN: final read beat returns now
    endcase

    // Memory data lags each enabled read cycle by one clock.
    rsp_valid_d = mem_en_q & ~mem_wren_q;
    rsp_index_d = (rsp_valid_q && !rsp_last) ? rsp_index_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q        <= ST_IDLE;
      issue_cnt_q    <= '0;
      last_idx_q     <= '0;
      mem_addr_q     <= '0;
      mem_acc_size_q <= '0;
      mem_en_q       <= 1'b0;
      mem_wren_q     <= 1'b0;
      mem_d_in_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_index_q    <= '0;
      wr_done_q      <= 1'b0;
      req_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      issue_cnt_q    <= issue_cnt_d;
      last_idx_q     <= last_idx_d;
      mem_addr_q     <= mem_addr_d;
      mem_acc_size_q <= mem_acc_size_d;
      mem_en_q       <= mem_en_d;
      mem_wren_q     <= mem_wren_d;
      mem_d_in_q     <= mem_d_in_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_index_q    <= rsp_index_d;
      wr_done_q      <= wr_done_d;
      req_err_q      <= req_err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = mem_d_out;
  assign rsp_index    = rsp_index_q;
  assign rsp_last     = rsp_valid_q && (rsp_index_q == last_idx_q);
  assign wr_done      = wr_done_q;
  assign req_err      = req_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_acc_size = mem_acc_size_q;
  assign mem_en       = mem_en_q;
  assign mem_wren     = mem_wren_q;
  assign mem_d_in     = mem_d_in_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_master
//
// Bench for mem_burst_master. A simple burst memory answers the DUT's memory
// port; a separate reference array holds the contents the client expects to
// read back, and every expected beat, index, flag and timing point is derived
// from the request (address, word count N) with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_burst_master;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam int          MW   = 1024;          // words modelled in the window

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_last, wr_done, req_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_index;
  logic [31:0] mem_addr, mem_d_in, mem_d_out;
  logic [1:0]  mem_acc_size;
  logic        mem_en, mem_wren, mem_busy;

  logic [31:0] mem     [MW];   // storage seen by the DUT
  logic [31:0] ref_mem [MW];   // what the client should read back
  logic        mem_en_prev = 1'b0;
  int          mem_off = 0;

  int tests  = 0;
  int failed = 0;

  mem_burst_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_index(rsp_index),
    .rsp_last(rsp_last), .wr_done(wr_done), .req_err(req_err),
    .mem_addr(mem_addr), .mem_acc_size(mem_acc_size), .mem_en(mem_en),
    .mem_wren(mem_wren), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
    .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // Burst memory: a fresh run of mem_en restarts at offset 0, each further
  // enabled cycle steps one word. Read data is registered.
  always @(posedge clk) begin
    int o;
    o = mem_en_prev ? mem_off + 1 : 0;
    if (mem_en) begin
      if (mem_wren) mem[(widx(mem_addr) + o) % MW] <= mem_d_in;
      else          mem_d_out <= mem[(widx(mem_addr) + o) % MW];
      mem_off <= o;
    end
    mem_en_prev <= mem_en;
  end
  assign mem_busy = mem_en;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 2;
    return int'(d[9:0]);
  endfunction

  function automatic int words_of(input logic [1:0] code);
    return (code == 2'd0) ? 1 : (code == 2'd1) ? 4 : (code == 2'd2) ? 8 : 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"},    req_ready,    1);
    check({tag, "_rsp_valid"},    rsp_valid,    0);
    check({tag, "_rsp_index"},    rsp_index,    0);
    check({tag, "_rsp_last"},     rsp_last,     0);
    check({tag, "_wr_done"},      wr_done,      0);
    check({tag, "_req_err"},      req_err,      0);
    check({tag, "_mem_addr"},     mem_addr,     0);
    check({tag, "_mem_acc_size"}, mem_acc_size, 0);
    check({tag, "_mem_en"},       mem_en,       0);
    check({tag, "_mem_wren"},     mem_wren,     0);
    check({tag, "_mem_d_in"},     mem_d_in,     0);
  endtask

  // Burst read. With hammer set, junk requests are driven while the block is
  // busy; they must be ignored.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input bit hammer);
    int n;
    n = words_of(size);
    req_wr = 1'b0; req_addr = addr; req_size = size; req_wdata = $urandom; req_valid = 1'b1;
    check("rd_t0_ready", req_ready, 1);
    tick();
    for (int c = 1; c <= n + 2; c++) begin
      bit en_exp, v_exp;
      int k;
      en_exp = (c <= n);
      v_exp  = (c >= 2) && (c <= n + 1);
      k      = c - 2;
      check("rd_mem_en", mem_en, en_exp);
      if (en_exp) begin
        check("rd_mem_addr", mem_addr, addr);
        check("rd_acc_size", mem_acc_size, size);
        check("rd_mem_wren", mem_wren, 0);
      end
      check("rd_rsp_valid", rsp_valid, v_exp);
      if (v_exp) begin
        check("rd_rsp_data",  rsp_data,  ref_mem[(widx(addr) + k) % MW]);
        check("rd_rsp_index", rsp_index, k);
        check("rd_rsp_last",  rsp_last,  k == n - 1);
      end
      check("rd_req_ready", req_ready, c == n + 2);
      check("rd_wr_done",   wr_done,   0);
      if (c < n + 2) begin
        if (hammer) begin
          req_valid = 1'($urandom_range(0, 1));
          req_wr    = 1'($urandom_range(0, 1));
          req_addr  = $urandom;
          req_size  = 2'($urandom_range(0, 3));
        end else begin
          req_valid = 1'b0;
        end
        tick();
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    req_wr = 1'b1; req_addr = addr; req_size = 2'($urandom_range(0, 3));
    req_wdata = data; req_valid = 1'b1;
    check("wr_t0_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("wr_t1_mem_en",   mem_en,       1);
    check("wr_t1_mem_wren", mem_wren,     1);
    check("wr_t1_mem_addr", mem_addr,     addr);
    check("wr_t1_mem_d_in", mem_d_in,     data);
    check("wr_t1_acc_size", mem_acc_size, 0);
    check("wr_t1_wr_done",  wr_done,      0);
    check("wr_t1_ready",    req_ready,    0);
    tick();
    check("wr_t2_mem_en",   mem_en,    0);
    check("wr_t2_wr_done",  wr_done,   1);
    check("wr_t2_rsp_val",  rsp_valid, 0);
    check("wr_t2_ready",    req_ready, 0);
    tick();
    check("wr_t3_ready",    req_ready, 1);
    check("wr_t3_wr_done",  wr_done,   0);
    check("wr_t3_rsp_val",  rsp_valid, 0);
    ref_mem[widx(addr)] = data;
  endtask

`ifdef MEM_ADDR_CHECK_EN
  task automatic do_reject(input logic [31:0] addr, input logic [1:0] size);
    req_wr = 1'b0; req_addr = addr; req_size = size; req_valid = 1'b1;
    check("rej_t0_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("rej_t1_req_err", req_err,   1);
    check("rej_t1_mem_en",  mem_en,    0);
    check("rej_t1_ready",   req_ready, 0);
    tick();
    check("rej_t2_req_err", req_err,   0);
    check("rej_t2_mem_en",  mem_en,    0);
    check("rej_t2_ready",   req_ready, 1);
    check("rej_t2_rsp_val", rsp_valid, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    for (int i = 0; i < MW; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;

    // Power-on reset held for two cycles.
    tick(); tick();
    check_reset_state("por");
    rst = 1'b0;
    tick();

    // Single read, 16-beat burst, write followed by read-back.
    do_read(BASE, 2'b00, 1'b0);
    do_read(BASE + 32'h40, 2'b11, 1'b1);
    do_write(BASE + 32'h10, 32'h1234_5678);
    do_read(BASE + 32'h10, 2'b00, 1'b0);

    // Reset during an 8-word burst at t4: nothing more is issued or returned.
    req_wr = 1'b0; req_addr = BASE + 32'h100; req_size = 2'b10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("rstb_mem_en_pre", mem_en, 1);
      if (c < 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rstb_t5");
    for (int c = 6; c <= 12; c++) begin
      tick();
      check("rstb_mem_en_post",    mem_en,    0);
      check("rstb_rsp_valid_post", rsp_valid, 0);
    end
    do_read(BASE + 32'h100, 2'b10, 1'b0);

    // Reset while idle, with non-zero command registers.
    do_write(BASE + 32'h24, 32'hA5A5_0F0F);
    rst = 1'b1;
    tick(); tick();
    check_reset_state("idle_rst");
    rst = 1'b0;
    tick();

`ifdef MEM_ADDR_CHECK_EN
    do_reject(32'h8002_0002, 2'b00);
    do_reject(32'h8001_FFFC, 2'b00);
    do_reject(BASE + 32'd1048576 - 32'd60, 2'b11);
`endif

    // Randomized mix of writes and reads of every size.
    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      a = BASE + 32'($urandom_range(0, 900)) * 32'd4;
      if ($urandom_range(0, 3) == 0) do_write(a, $urandom);
      else do_read(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
